// File: rtl/dcache_pkg.sv
// Shared types and geometry for the write-through data cache.
package dcache_pkg;

  localparam int unsigned INDEX_BITS = 8;
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/data storage: combinational read port, synchronous write port,
// valid flops cleared together on reset.
module dcache_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_W      = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags  [LINES];
  logic [DATA_WIDTH-1:0] words [LINES];

  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (wr_en)
      valid[wr_index] <= 1'b1;
  end

  // A write racing with reset is dropped so a reset line never holds stale fill data.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// single-outstanding-request handshake to backing memory.
module dcache_wt #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  import dcache_pkg::*;

  localparam int unsigned TAG_W = DATA_WIDTH - INDEX_BITS - 2;

  dcache_state_t state;

  logic [DATA_WIDTH-1:0] word_addr;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic                  hit;
  logic                  load_hit;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  assign word_addr = req_addr & ~DATA_WIDTH'(3);

  dcache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (word_addr[INDEX_BITS+1:2]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (rdata),
    .wr_en    (wr_en),
    .wr_index (mem_addr[INDEX_BITS+1:2]),
    .wr_tag   (mem_addr[DATA_WIDTH-1:INDEX_BITS+2]),
    .wr_data  (wr_data)
  );

  assign hit      = line_valid && (line_tag == word_addr[DATA_WIDTH-1:INDEX_BITS+2]);
  assign load_hit = req_valid && !req_we && hit;

  // Fills always write; write-through only refreshes a line already holding this tag.
  assign wr_en   = mem_ready && ((state == RD_MISS) || ((state == WR_THRU) && hit));
  assign wr_data = (state == RD_MISS) ? mem_rdata : mem_wdata;

  assign stall = ((state == IDLE) && req_valid && !load_hit)
              || (state == RD_MISS) || (state == WR_THRU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (load_hit) begin
              hit_count <= hit_count + 32'd1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= word_addr;
              mem_wdata <= req_wdata;
              if (req_we) begin
                state <= WR_THRU;
              end else begin
                state      <= RD_MISS;
                miss_count <= miss_count + 32'd1;
              end
            end
          end
        end
        RD_MISS, WR_THRU: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt with a scripted backing-memory responder.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_wt #(
    .DATA_WIDTH (32),
    .INDEX_BITS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Holds one request until it completes; raises mem_ready on the lat-th cycle of mem_req.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] mdata,
                        output int nstall, output int nreq, output logic [31:0] rd,
                        output logic [31:0] maddr, output logic mwe, output logic [31:0] mwd);
    int w;
    nstall = 0; nreq = 0; w = 0;
    maddr = 32'hFFFF_FFFF; mwe = 1'bx; mwd = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; mem_ready = 1'b0;
    #1;
    while (stall && nstall <= 50) begin
      nstall++;
      if (mem_req) begin
        nreq++; w++;
        maddr = mem_addr; mwe = mem_we; mwd = mem_wdata;
        if (w >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = mdata;
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
    end
    rd = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (hit_count !== 32'h0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
    n_cmp++; if (miss_count !== 32'h0) begin n_bad++; $display("FAIL reset_misses: got %0d want 0", miss_count); end
  endtask

  task automatic test_cold_load();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    access(1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 4) begin n_bad++; $display("FAIL cold_stall_cycles: got %0d want 4", ns); end
    n_cmp++; if (nr !== 3) begin n_bad++; $display("FAIL cold_req_cycles: got %0d want 3", nr); end
    n_cmp++; if (ma !== 32'h100) begin n_bad++; $display("FAIL cold_mem_addr: got %h want 00000100", ma); end
    n_cmp++; if (mw !== 1'b0) begin n_bad++; $display("FAIL cold_mem_we: got %b want 0", mw); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL cold_misses: got %0d want 1", miss_count); end
    access(1'b0, 32'h100, 32'h0, 1, 32'h0BAD0BAD, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL reload_stall: got %0d want 0", ns); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reload_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL reload_hits: got %0d want 1", hit_count); end
  endtask

  task automatic test_misaligned();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    access(1'b0, 32'h103, 32'h0, 1, 32'h0BAD0BAD, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL misalign_hit_stall: got %0d want 0", ns); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL misalign_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (hit_count !== 32'd2) begin n_bad++; $display("FAIL misalign_hits: got %0d want 2", hit_count); end
    access(1'b0, 32'h107, 32'h0, 1, 32'h0000A5A5, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL misalign_miss_stall: got %0d want 2", ns); end
    n_cmp++; if (ma !== 32'h104) begin n_bad++; $display("FAIL misalign_mem_addr: got %h want 00000104", ma); end
    n_cmp++; if (rd !== 32'h0000A5A5) begin n_bad++; $display("FAIL misalign_fill: got %h want 0000a5a5", rd); end
    n_cmp++; if (miss_count !== 32'd2) begin n_bad++; $display("FAIL misalign_misses: got %0d want 2", miss_count); end
  endtask

  task automatic test_store_hit();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    access(1'b0, 32'h200, 32'h0, 2, 32'h11111111, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL sthit_fill_stall: got %0d want 3", ns); end
    access(1'b1, 32'h200, 32'h12345678, 1, 32'h0, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL sthit_stall: got %0d want 2", ns); end
    n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL sthit_req_cycles: got %0d want 1", nr); end
    n_cmp++; if (ma !== 32'h200) begin n_bad++; $display("FAIL sthit_mem_addr: got %h want 00000200", ma); end
    n_cmp++; if (mw !== 1'b1) begin n_bad++; $display("FAIL sthit_mem_we: got %b want 1", mw); end
    n_cmp++; if (mwd !== 32'h12345678) begin n_bad++; $display("FAIL sthit_mem_wdata: got %h want 12345678", mwd); end
    n_cmp++; if (miss_count !== 32'd3 || hit_count !== 32'd2) begin n_bad++;
      $display("FAIL sthit_counters: got hits %0d misses %0d want hits 2 misses 3", hit_count, miss_count); end
    access(1'b0, 32'h200, 32'h0, 1, 32'h0BAD0BAD, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 0 || nr !== 0) begin n_bad++; $display("FAIL sthit_reload_stall: got stall %0d req %0d want 0 0", ns, nr); end
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL sthit_reload_rdata: got %h want 12345678", rd); end
  endtask

  task automatic test_store_miss();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    access(1'b1, 32'h300, 32'hCAFEF00D, 2, 32'h0, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL stmiss_stall: got %0d want 3", ns); end
    n_cmp++; if (mw !== 1'b1 || ma !== 32'h300) begin n_bad++;
      $display("FAIL stmiss_write: got we %b addr %h want we 1 addr 00000300", mw, ma); end
    access(1'b0, 32'h300, 32'h0, 1, 32'hCAFEF00D, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL stmiss_no_allocate: got %0d want 2", ns); end
    n_cmp++; if (miss_count !== 32'd4) begin n_bad++; $display("FAIL stmiss_misses: got %0d want 4", miss_count); end
  endtask

  task automatic test_conflict();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw; logic [31:0] m0;
    m0 = miss_count;
    access(1'b0, 32'h000, 32'h0, 1, 32'h0000000A, ns, nr, rd, ma, mw, mwd);
    access(1'b0, 32'h400, 32'h0, 1, 32'h0000000B, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (rd !== 32'h0000000B) begin n_bad++; $display("FAIL conflict_evict_rdata: got %h want 0000000b", rd); end
    access(1'b0, 32'h000, 32'h0, 1, 32'h0000000A, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL conflict_reload_stall: got %0d want 2", ns); end
    n_cmp++; if (miss_count - m0 !== 32'd3) begin n_bad++; $display("FAIL conflict_misses: got %0d want 3", miss_count - m0); end
    access(1'b1, 32'h400, 32'h000000BB, 1, 32'h0, ns, nr, rd, ma, mw, mwd);
    access(1'b0, 32'h000, 32'h0, 1, 32'h0BAD0BAD, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 0 || rd !== 32'h0000000A) begin n_bad++;
      $display("FAIL conflict_store_other_tag: got stall %0d data %h want 0 0000000a", ns, rd); end
  endtask

  task automatic test_reset_mid_miss();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500;
    @(posedge clk); #2;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_miss: got %b want 1", mem_req); end
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h55AA55AA; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_idle: got mem_req %b stall %b want 0 0", mem_req, stall); end
    n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_bad++;
      $display("FAIL rstmid_counters: got hits %0d misses %0d want 0 0", hit_count, miss_count); end
    access(1'b0, 32'h500, 32'h0, 1, 32'h77777777, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2 || rd !== 32'h77777777) begin n_bad++;
      $display("FAIL rstmid_line_unwritten: got stall %0d data %h want 2 77777777", ns, rd); end
    access(1'b0, 32'h100, 32'h0, 1, 32'h01010101, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 2) begin n_bad++; $display("FAIL rstmid_all_invalid: got %0d want 2", ns); end
    n_cmp++; if (miss_count !== 32'd2) begin n_bad++; $display("FAIL rstmid_misses: got %0d want 2", miss_count); end
  endtask

  task automatic test_ready_ignored();
    int ns, nr; logic [31:0] rd, ma, mwd; logic mw;
    mem_ready = 1'b1; mem_rdata = 32'hEEEEEEEE;
    @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL ready_idle: got mem_req %b stall %b want 0 0", mem_req, stall); end
    access(1'b0, 32'h100, 32'h0, 1, 32'h0BAD0BAD, ns, nr, rd, ma, mw, mwd);
    n_cmp++; if (ns !== 0 || rd !== 32'h01010101) begin n_bad++;
      $display("FAIL ready_line_kept: got stall %0d data %h want 0 01010101", ns, rd); end
    n_cmp++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL ready_hits: got %0d want 1", hit_count); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_misaligned();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_miss();
    test_ready_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
